ekf_stage_sched: RTL
====================

Name: ekf_stage_sched

Overview:
- Front-end scheduler for the PE_config / systolic-array datapath.
- Accepts predict (PRD), new-landmark (NEW) and update (UPD) requests from the top-level EKF controller, arbitrates them, and issues one-hot stage_val to PE_config.
- Tracks PE_config busy/ready, owns the landmark count, and reports completion or errors per stage.

Parameters:
ROW_LEN, 10, width of landmark count/index
MAX_LM, 500, maximum landmarks; NEW rejected at this count
WDT_DW, 16, watchdog counter width (used only with the optional feature)
WDT_LIMIT, 40000, cycles allowed per stage before abort

Ports:
clk  in  1  system clock, rising edge
sys_rst  in  1  asynchronous active-low reset
req_val  in  3  request bits: [0]=PRD, [1]=NEW, [2]=UPD; level, may be multi-hot
req_lm_idx  in  ROW_LEN  landmark index for UPD, sampled on accept
req_rdy  out  1  request accepted this cycle when req_rdy & |req_val
lm_clr  in  1  clear landmark_num; honoured only in IDLE
stage_val  out  3  one-hot stage to PE_config: 001 PRD, 010 NEW, 100 UPD
stage_rdy  in  3  PE_config status: 3'b111 ready, any other value busy
lm_idx  out  ROW_LEN  latched landmark index presented to datapath
landmark_num  out  ROW_LEN  current landmark count
done  out  3  one-cycle pulse, bit per stage, on completion
err  out  2  one-cycle pulse: 01 invalid request, 10 watchdog abort
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, sys_rst low): state IDLE; stage_val=0, lm_idx=0, landmark_num=0, done=0, err=0, busy=0, req_rdy=0; watchdog cleared.
- req_rdy is combinational: 1 iff state==IDLE and stage_rdy==3'b111.
- Arbitration on accept: fixed priority PRD > UPD > NEW. Only the winning bit is consumed. The requester must deassert its bit; lower-priority bits still set are re-arbitrated in a later IDLE cycle.
- Validity check, in the accept cycle:
  - UPD with req_lm_idx >= landmark_num (including landmark_num==0) -> err=01 next cycle; stay IDLE; nothing issued.
  - NEW with landmark_num==MAX_LM -> err=01; stay IDLE.
- Valid accept:
  - Latch the stage into a one-hot register.
  - lm_idx <= req_lm_idx for UPD; lm_idx <= landmark_num for NEW. PRD leaves lm_idx unchanged.
  - -> ISSUE.
- ISSUE:
  - stage_val = latched one-hot, held until stage_rdy != 3'b111 is sampled.
  - The cycle busy is sampled, stage_val drops to 0 (registered, so stage_val is low from the next cycle) -> WAIT_DONE.
  - Minimum stage_val assertion is 1 cycle.
- WAIT_DONE: stage_val=0; when stage_rdy==3'b111 -> DONE.
- DONE, 1 cycle:
  - done[stage] pulses.
  - If the stage was NEW, landmark_num <= landmark_num+1, visible the same cycle the done pulse is visible.
  - -> IDLE.
- Completion latency: next request can be accepted 1 cycle after the done pulse.
- lm_clr:
  - In IDLE: landmark_num<=0 next cycle. If asserted together with an accepted request, the clear wins and the request is not accepted (req_rdy forced 0 that cycle).
  - Outside IDLE: ignored.
- stage_rdy values other than 111/000 are treated as busy.
- landmark_num never wraps; saturates at MAX_LM via the NEW rejection.
- done and err never assert in the same cycle.

Optional Feature:
- Macro STAGE_WDT_EN.
- Defined:
  - A WDT_DW-bit counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT_DONE.
  - On reaching WDT_LIMIT: err=10 pulse, stage_val<=0, no done, landmark_num unchanged, -> IDLE.
- Undefined:
  - No counter or WDT_LIMIT logic is synthesised.
  - Scheduler waits indefinitely; err[1] is tied 0.

Test Plan:
- Reset mid-stage: assert sys_rst low while in WAIT_DONE with stage_val previously 010 -> all outputs 0 immediately (async), landmark_num=0, no done pulse after release.
- Single PRD: req_val=001 with stage_rdy=111; model drops stage_rdy to 000 two cycles later, returns 111 after 20 cycles -> stage_val=001 for exactly 2 cycles, then 0, done=001 one cycle after ready, landmark_num stays 0.
- Priority plus NEW count: req_val=111 held, landmark_num=0 -> order PRD, then UPD rejected (err=01, idx 0 >= 0), then NEW issued -> done=010, landmark_num=1; then UPD idx 0 accepted -> stage_val=100, lm_idx=0.
- Saturation: landmark_num driven to MAX_LM=500 via repeated NEW -> 501st NEW gives err=01, landmark_num stays 500.
- lm_clr contention: lm_clr=1 with req_val=010 in IDLE -> req_rdy=0, landmark_num=0 next cycle, NEW accepted the following cycle.
- Watchdog, STAGE_WDT_EN defined with WDT_LIMIT=100: PE_config never returns to 111 -> err=10 exactly 100 cycles after ISSUE entry, no done, state IDLE. Without the macro, the same stimulus leaves busy=1 indefinitely.

Source files
------------

// File: rtl/ekf_stage_sched.sv
// ekf_stage_sched: arbitrates PRD/NEW/UPD requests and sequences one stage at a time into PE_config.
// Optional per-stage watchdog is built only when STAGE_WDT_EN is defined.
module ekf_stage_sched #(
    parameter int ROW_LEN   = 10,
    parameter int MAX_LM    = 500,
    parameter int WDT_DW    = 16,
    parameter int WDT_LIMIT = 40000
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic [2:0]         req_val,
    input  logic [ROW_LEN-1:0] req_lm_idx,
    output logic               req_rdy,
    input  logic               lm_clr,
    output logic [2:0]         stage_val,
    input  logic [2:0]         stage_rdy,
    output logic [ROW_LEN-1:0] lm_idx,
    output logic [ROW_LEN-1:0] landmark_num,
    output logic [2:0]         done,
    output logic [1:0]         err,
    output logic               busy
);

    localparam logic [2:0]         ST_PRD   = 3'b001;
    localparam logic [2:0]         ST_NEW   = 3'b010;
    localparam logic [2:0]         ST_UPD   = 3'b100;
    localparam logic [ROW_LEN-1:0] MAX_LM_W = ROW_LEN'(MAX_LM);

    // The landmark count must fit its port and the watchdog limit must fit its counter.
    if (MAX_LM >= (1 << ROW_LEN) || WDT_LIMIT < 1 || WDT_LIMIT > (1 << WDT_DW)) begin : g_cfg_check
        $error("ekf_stage_sched: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [2:0]         stage_oh;
    logic [2:0]         win;
    logic               pe_ready;
    logic               accept;
    logic               req_ok;
    logic               accept_ok;
    logic               accept_bad;
    logic               in_stage;
    logic               wdt_abort;
    logic [2:0]         stage_val_nx;
    logic [2:0]         done_nx;
    logic [1:0]         err_nx;
    logic [ROW_LEN-1:0] lm_num_nx;
    logic [ROW_LEN-1:0] lm_idx_nx;

    function automatic logic [2:0] arb_pick(input logic [2:0] r);
        if (r[0]) return ST_PRD;
        if (r[2]) return ST_UPD;
        if (r[1]) return ST_NEW;
        return 3'b000;
    endfunction

    function automatic logic [ROW_LEN-1:0] sat_inc(input logic [ROW_LEN-1:0] v);
        return (v >= MAX_LM_W) ? MAX_LM_W : v + 1'b1;
    endfunction

    assign pe_ready   = (stage_rdy == 3'b111);
    assign in_stage   = (state == ISSUE) || (state == WAIT_DONE);
    assign busy       = (state != IDLE);
    // A pending clear takes the IDLE cycle, so no request is taken alongside it.
    assign req_rdy    = sys_rst & (state == IDLE) & pe_ready & ~lm_clr;
    assign win        = arb_pick(req_val);
    assign accept     = req_rdy & (|req_val);
    assign accept_ok  = accept & req_ok;
    assign accept_bad = accept & ~req_ok;

    always_comb begin
        req_ok = 1'b1;
        case (win)
            ST_UPD:  req_ok = (req_lm_idx < landmark_num);
            ST_NEW:  req_ok = (landmark_num < MAX_LM_W);
            default: req_ok = 1'b1;
        endcase
    end

`ifdef STAGE_WDT_EN
    localparam logic [WDT_DW-1:0] WDT_LAST = WDT_DW'(WDT_LIMIT - 1);

    logic [WDT_DW-1:0] wdt_cnt;

    // Zero on the first ISSUE cycle, so the abort lands WDT_LIMIT cycles after entry.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wdt_cnt <= '0;
        end else if (in_stage) begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end else begin
            wdt_cnt <= '0;
        end
    end

    assign wdt_abort = in_stage && (wdt_cnt == WDT_LAST);
`else
    assign wdt_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept_ok) state_nx = ISSUE;
            end
            ISSUE: begin
                if (wdt_abort)      state_nx = IDLE;
                else if (!pe_ready) state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (wdt_abort)     state_nx = IDLE;
                else if (pe_ready) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        stage_val_nx = 3'b000;
        done_nx      = 3'b000;
        err_nx       = 2'b00;
        lm_num_nx    = landmark_num;
        lm_idx_nx    = lm_idx;
        case (state)
            IDLE: begin
                if (lm_clr) lm_num_nx = '0;
                if (accept_bad) err_nx = 2'b01;
                if (accept_ok) begin
                    stage_val_nx = win;
                    if (win == ST_UPD)      lm_idx_nx = req_lm_idx;
                    else if (win == ST_NEW) lm_idx_nx = landmark_num;
                end
            end
            ISSUE: begin
                // Hold the request until PE_config is seen busy.
                if (!wdt_abort && pe_ready) stage_val_nx = stage_oh;
            end
            WAIT_DONE: begin
                if (!wdt_abort && pe_ready) begin
                    done_nx = stage_oh;
                    if (stage_oh == ST_NEW) lm_num_nx = sat_inc(landmark_num);
                end
            end
            default: begin
            end
        endcase
        if (wdt_abort) err_nx = 2'b10;
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            stage_oh     <= '0;
            stage_val    <= '0;
            lm_idx       <= '0;
            landmark_num <= '0;
            done         <= '0;
            err          <= '0;
        end else begin
            if (accept_ok) stage_oh <= win;
            stage_val    <= stage_val_nx;
            lm_idx       <= lm_idx_nx;
            landmark_num <= lm_num_nx;
            done         <= done_nx;
            err          <= err_nx;
        end
    end

endmodule
